// File: rtl/sd_rrsched.sv
// Round-robin scheduler sharing one srdy/drdy datapath among `inputs` requesters, with optional packet lock.
// One registered output stage: 1-cycle latency, full throughput; p_drdy low holds the word and stalls every c_drdy.
module sd_rrsched #(
    parameter int width  = 8,
    parameter int inputs = 4,
    parameter int lock   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [inputs-1:0]         c_srdy,
    output logic [inputs-1:0]         c_drdy,
    input  logic [inputs*width-1:0]   c_data,
    input  logic [inputs-1:0]         c_eop,
    output logic                      p_srdy,
    input  logic                      p_drdy,
    output logic [width-1:0]          p_data,
    output logic                      p_eop,
    output logic [inputs-1:0]         p_grant
);

    localparam int PW = (inputs > 1) ? $clog2(inputs) : 1;
    localparam logic [PW-1:0] LAST = PW'(inputs - 1);
    localparam bit LOCK_EN = (lock != 0);

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     lock_idx;
    logic              locked;
    logic [PW-1:0]     win;
    logic [PW-1:0]     nxt_ptr;
    logic [inputs-1:0] win_oh;
    logic [width-1:0]  win_data;
    logic              win_eop;
    logic              ld;
    logic              xfer;

    // Scan from ptr with explicit wrap so non-power-of-2 counts never visit unused indices.
    always_comb begin : arbitrate
        logic          found;
        logic [PW-1:0] idx;
        win   = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < inputs; k++) begin
            if (!found && c_srdy[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = (idx == LAST) ? '0 : idx + PW'(1);
        end
        if (locked) begin
            win = lock_idx;
        end
    end

    always_comb begin : select
        win_oh   = '0;
        win_data = '0;
        win_eop  = 1'b0;
        for (int i = 0; i < inputs; i++) begin
            if (win == PW'(i)) begin
                win_oh[i] = 1'b1;
                win_data  = c_data[i*width +: width];
                win_eop   = c_eop[i];
            end
        end
    end

    assign ld      = !p_srdy || p_drdy;
    assign c_drdy  = win_oh & c_srdy & {inputs{ld && !reset}};
    assign xfer    = |c_drdy;
    assign nxt_ptr = (win == LAST) ? '0 : win + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_srdy   <= 1'b0;
            p_data   <= '0;
            p_eop    <= 1'b0;
            p_grant  <= '0;
            ptr      <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (xfer) begin
                p_srdy  <= 1'b1;
                p_data  <= win_data;
                p_eop   <= win_eop;
                p_grant <= win_oh;
                // Mid-packet words pin the grant; pointer only advances when the grant is released.
                if (LOCK_EN && !win_eop) begin
                    locked   <= 1'b1;
                    lock_idx <= win;
                end else begin
                    locked <= 1'b0;
                    ptr    <= nxt_ptr;
                end
            end else if (p_drdy) begin
                p_srdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sd_rrsched.sv
// Bench for sd_rrsched: three instances (4 inputs unlocked, 4 inputs locked, 3 inputs unlocked).
module tb_sd_rrsched;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
        logic [3:0] g;
    } word_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    word_t q[$];

    logic [3:0]  a_srdy, a_drdy, a_eop, a_pgrant;
    logic [31:0] a_data;
    logic        a_psrdy, a_pdrdy, a_peop;
    logic [7:0]  a_pdata;

    logic [3:0]  b_srdy, b_drdy, b_eop, b_pgrant;
    logic [31:0] b_data;
    logic        b_psrdy, b_pdrdy, b_peop;
    logic [7:0]  b_pdata;

    logic [2:0]  t_srdy, t_drdy, t_eop, t_pgrant;
    logic [23:0] t_data;
    logic        t_psrdy, t_pdrdy, t_peop;
    logic [7:0]  t_pdata;

    sd_rrsched #(.width(8), .inputs(4), .lock(0)) u_a (
        .clk(clk), .reset(reset), .c_srdy(a_srdy), .c_drdy(a_drdy), .c_data(a_data), .c_eop(a_eop),
        .p_srdy(a_psrdy), .p_drdy(a_pdrdy), .p_data(a_pdata), .p_eop(a_peop), .p_grant(a_pgrant));

    sd_rrsched #(.width(8), .inputs(4), .lock(1)) u_b (
        .clk(clk), .reset(reset), .c_srdy(b_srdy), .c_drdy(b_drdy), .c_data(b_data), .c_eop(b_eop),
        .p_srdy(b_psrdy), .p_drdy(b_pdrdy), .p_data(b_pdata), .p_eop(b_peop), .p_grant(b_pgrant));

    sd_rrsched #(.width(8), .inputs(3), .lock(0)) u_t (
        .clk(clk), .reset(reset), .c_srdy(t_srdy), .c_drdy(t_drdy), .c_data(t_data), .c_eop(t_eop),
        .p_srdy(t_psrdy), .p_drdy(t_pdrdy), .p_data(t_pdata), .p_eop(t_peop), .p_grant(t_pgrant));

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        a_srdy = 4'b1111; a_eop = '0; a_data = 32'h33221100; a_pdrdy = 1'b1;
        b_srdy = 4'b1111; b_eop = '0; b_data = 32'h77665544; b_pdrdy = 1'b1;
        t_srdy = 3'b111;  t_eop = '0; t_data = 24'h aa9988;  t_pdrdy = 1'b1;
        @(negedge clk);
        checks++; if (a_psrdy !== 1'b0) begin errors++; $display("FAIL reset_a_psrdy: got %b want 0", a_psrdy); end
        checks++; if (a_drdy !== 4'b0000) begin errors++; $display("FAIL reset_a_drdy: got %b want 0000", a_drdy); end
        checks++; if (a_pgrant !== 4'b0000 || a_pdata !== 8'h00 || a_peop !== 1'b0) begin
            errors++; $display("FAIL reset_a_out: got grant %b data %h eop %b want 0000 00 0", a_pgrant, a_pdata, a_peop); end
        checks++; if (b_drdy !== 4'b0000 || b_psrdy !== 1'b0) begin
            errors++; $display("FAIL reset_b: got drdy %b psrdy %b want 0000 0", b_drdy, b_psrdy); end
        checks++; if (t_drdy !== 3'b000 || t_psrdy !== 1'b0) begin
            errors++; $display("FAIL reset_t: got drdy %b psrdy %b want 000 0", t_drdy, t_psrdy); end
        a_srdy = '0; b_srdy = '0; t_srdy = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // All four requesting from ptr=0: strict rotation with no output bubbles.
    task automatic test_rotation();
        int cnt[4];
        int w;
        logic [3:0] exp;
        word_t ew, got;
        bit pend = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        @(posedge clk); #1;
        a_srdy = 4'b1111; a_eop = '0; a_pdrdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 4; i++) a_data[i*8 +: 8] = 8'(16*i + cnt[i]);
            w = k % 4;
            exp = 4'(1 << w);
            @(negedge clk);
            if (pend) begin
                got = {a_pdata, a_peop, a_pgrant}; ew = q.pop_front();
                checks++; if (a_psrdy !== 1'b1 || got !== ew) begin
                    errors++; $display("FAIL rot_out[%0d]: got srdy %b word %h want 1 %h", k, a_psrdy, got, ew); end
            end
            checks++; if (a_drdy !== exp) begin errors++; $display("FAIL rot_drdy[%0d]: got %b want %b", k, a_drdy, exp); end
            ew = {8'(16*w + cnt[w]), 1'b0, exp}; q.push_back(ew); pend = 1'b1;
            @(posedge clk); #1;
            cnt[w]++;
        end
        a_srdy = '0;
        @(negedge clk);
        got = {a_pdata, a_peop, a_pgrant}; ew = q.pop_front();
        checks++; if (a_psrdy !== 1'b1 || got !== ew) begin
            errors++; $display("FAIL rot_out_last: got srdy %b word %h want 1 %h", a_psrdy, got, ew); end
    endtask

    task automatic test_single();
        word_t ew, got;
        bit pend = 1'b0;
        @(posedge clk); #1;
        a_srdy = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) a_srdy = '0;
            a_data[23:16] = 8'(8'h50 + k);
            @(negedge clk);
            if (pend) begin
                got = {a_pdata, a_peop, a_pgrant}; ew = q.pop_front();
                checks++; if (a_psrdy !== 1'b1 || got !== ew) begin
                    errors++; $display("FAIL single_out[%0d]: got srdy %b word %h want 1 %h", k, a_psrdy, got, ew); end
            end
            if (k < 5) begin
                checks++; if (a_drdy !== 4'b0100) begin errors++; $display("FAIL single_drdy[%0d]: got %b want 0100", k, a_drdy); end
                ew = {8'(8'h50 + k), 1'b0, 4'b0100}; q.push_back(ew); pend = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    // Entry ptr is 3 (last grant was input 2), so input 0 wins the first word.
    task automatic test_backpressure();
        a_srdy = 4'b0001; a_data[7:0] = 8'hC0; a_pdrdy = 1'b1;
        @(negedge clk);
        checks++; if (a_drdy !== 4'b0001) begin errors++; $display("FAIL bp_first_drdy: got %b want 0001", a_drdy); end
        @(posedge clk); #1;
        a_pdrdy = 1'b0; a_srdy = 4'b0010; a_data[15:8] = 8'hD1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (a_drdy !== 4'b0000 || a_psrdy !== 1'b1 || a_pdata !== 8'hC0 || a_pgrant !== 4'b0001) begin
                errors++; $display("FAIL bp_stall[%0d]: got drdy %b srdy %b data %h grant %b want 0000 1 c0 0001",
                                   k, a_drdy, a_psrdy, a_pdata, a_pgrant); end
            @(posedge clk); #1;
        end
        a_pdrdy = 1'b1;
        @(negedge clk);
        checks++; if (a_drdy !== 4'b0010) begin errors++; $display("FAIL bp_release_drdy: got %b want 0010", a_drdy); end
        @(posedge clk); #1;
        a_srdy = '0;
        @(negedge clk);
        checks++; if (a_psrdy !== 1'b1 || a_pdata !== 8'hD1 || a_pgrant !== 4'b0010) begin
            errors++; $display("FAIL bp_reload: got srdy %b data %h grant %b want 1 d1 0010", a_psrdy, a_pdata, a_pgrant); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (a_psrdy !== 1'b0) begin errors++; $display("FAIL bp_drain: got psrdy %b want 0", a_psrdy); end
    endtask

    // Input 0 sends a 1-word packet (ptr->1), then input 1 locks for 3 words across a 2-cycle gap.
    task automatic test_lock();
        logic [3:0] srdy_t[8];
        logic [3:0] eop_t[8];
        logic [3:0] exp_t[8];
        int cnt[4];
        int w;
        word_t ew, got;
        bit pend = 1'b0;
        srdy_t = '{4'b0001, 4'b1011, 4'b1011, 4'b1001, 4'b1001, 4'b1011, 4'b1001, 4'b0000};
        eop_t  = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1011, 4'b1001, 4'b1001};
        exp_t  = '{4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0000};
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        @(posedge clk); #1;
        b_pdrdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            b_srdy = (k < 8) ? srdy_t[k] : 4'b0000;
            b_eop  = (k < 8) ? eop_t[k] : 4'b0000;
            for (int i = 0; i < 4; i++) b_data[i*8 +: 8] = 8'(8'h80 + 16*i + cnt[i]);
            @(negedge clk);
            if (pend) begin
                got = {b_pdata, b_peop, b_pgrant}; ew = q.pop_front();
                checks++; if (b_psrdy !== 1'b1 || got !== ew) begin
                    errors++; $display("FAIL lock_out[%0d]: got srdy %b word %h want 1 %h", k, b_psrdy, got, ew); end
            end else begin
                checks++; if (b_psrdy !== 1'b0) begin errors++; $display("FAIL lock_idle[%0d]: got psrdy %b want 0", k, b_psrdy); end
            end
            pend = 1'b0;
            if (k < 8) begin
                checks++; if (b_drdy !== exp_t[k]) begin
                    errors++; $display("FAIL lock_drdy[%0d]: got %b want %b", k, b_drdy, exp_t[k]); end
                w = -1;
                for (int i = 0; i < 4; i++) if (exp_t[k][i]) w = i;
                if (w >= 0) begin
                    ew = {8'(8'h80 + 16*w + cnt[w]), eop_t[k][w], exp_t[k]}; q.push_back(ew); pend = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (k < 8) for (int i = 0; i < 4; i++) if (exp_t[k][i]) cnt[i]++;
        end
    endtask

    task automatic test_reset_midpacket();
        b_srdy = 4'b0100; b_eop = '0; b_data = 32'h00E200E0; b_pdrdy = 1'b0;
        @(negedge clk);
        checks++; if (b_drdy !== 4'b0100) begin errors++; $display("FAIL mid_first_drdy: got %b want 0100", b_drdy); end
        @(posedge clk); #1;
        b_srdy = 4'b0101;
        @(negedge clk);
        checks++; if (b_psrdy !== 1'b1 || b_drdy !== 4'b0000) begin
            errors++; $display("FAIL mid_held: got psrdy %b drdy %b want 1 0000", b_psrdy, b_drdy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (b_psrdy !== 1'b0 || b_drdy !== 4'b0000 || b_pgrant !== 4'b0000 || b_pdata !== 8'h00) begin
            errors++; $display("FAIL mid_async: got psrdy %b drdy %b grant %b data %h want 0 0000 0000 00",
                               b_psrdy, b_drdy, b_pgrant, b_pdata); end
        b_pdrdy = 1'b1;
        #1;
        checks++; if (b_drdy !== 4'b0000) begin errors++; $display("FAIL mid_in_reset_drdy: got %b want 0000", b_drdy); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (b_drdy !== 4'b0001) begin errors++; $display("FAIL mid_after_drdy: got %b want 0001", b_drdy); end
        @(posedge clk); #1;
        b_srdy = '0;
        @(negedge clk);
        checks++; if (b_psrdy !== 1'b1 || b_pdata !== 8'hE0 || b_pgrant !== 4'b0001) begin
            errors++; $display("FAIL mid_after_out: got srdy %b data %h grant %b want 1 e0 0001", b_psrdy, b_pdata, b_pgrant); end
    endtask

    task automatic test_wrap3();
        int cnt[3];
        int w;
        logic [2:0] exp;
        word_t ew, got;
        bit pend = 1'b0;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        @(posedge clk); #1;
        t_srdy = 3'b111; t_pdrdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) t_srdy = '0;
            for (int i = 0; i < 3; i++) t_data[i*8 +: 8] = 8'(8'h30 + 16*i + cnt[i]);
            w = k % 3;
            exp = 3'(1 << w);
            @(negedge clk);
            if (pend) begin
                got = {t_pdata, t_peop, 1'b0, t_pgrant}; ew = q.pop_front();
                checks++; if (t_psrdy !== 1'b1 || got !== ew) begin
                    errors++; $display("FAIL wrap_out[%0d]: got srdy %b word %h want 1 %h", k, t_psrdy, got, ew); end
            end
            pend = 1'b0;
            if (k < 7) begin
                checks++; if (t_drdy !== exp) begin errors++; $display("FAIL wrap_drdy[%0d]: got %b want %b", k, t_drdy, exp); end
                ew = {8'(8'h30 + 16*w + cnt[w]), 1'b0, 1'b0, exp}; q.push_back(ew); pend = 1'b1;
            end
            @(posedge clk); #1;
            if (k < 7) cnt[w]++;
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single();
        test_backpressure();
        test_lock();
        test_reset_midpacket();
        test_wrap3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
